pipelined_adder: RTL

Parametrised, pipelined multi-bit adder; successor to the single-bit combinational half adder. Splits WIDTH-bit operands into STAGES equal slices, adding one slice per clock with the carry registered between stages. Accepts one operand pair per cycle under a valid/ready handshake with full backpressure. Sits between an upstream operand source and any downstream consumer of registered sums in the arithmetic datapath.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and elaboration helpers for the pipelined adder.
//   stage_ctrl_t    : per-stage control word {valid, carry}
//   width_divisible : legality check for the WIDTH/STAGES split
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctrl_t;

   // The operand must split into STAGES equal, non-empty slices.
   function automatic bit width_divisible(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Combinational SLICE-bit adder used by one pipeline stage.
//   a, b    : slice operands
//   cin     : carry into the slice LSB
//   s       : slice sum
//   cout    : carry out of the slice MSB
//   msb_cin : carry into the slice MSB (signed overflow detection)
// -----------------------------------------------------------------------------
module adder_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             msb_cin
);

   logic [SLICE:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
   assign s    = full[SLICE-1:0];
   assign cout = full[SLICE];

   // The MSB sum bit is a ^ b ^ carry-in, so the carry-in is recoverable
   // without a second adder chain.
   assign msb_cin = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder split into STAGES slices, one slice per clock, with the
// carry registered between stages. Valid/ready handshake, full backpressure,
// whole pipeline advances under a single global enable.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, carry_in      : operands and carry into bit 0
//   out_valid/out_ready : result handshake
//   sum                 : a + b + carry_in modulo 2^WIDTH
//   carry_out           : unsigned carry out of bit WIDTH-1
//   overflow            : signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int SLICE = WIDTH / STAGES;

   if (!width_divisible(WIDTH, STAGES)) begin : g_param_check
      $error("pipelined_adder: WIDTH (%0d) must split evenly into STAGES (%0d)",
             WIDTH, STAGES);
   end

   stage_ctrl_t      ctrl_q    [STAGES];
   stage_ctrl_t      ctrl_d    [STAGES];
   logic [WIDTH-1:0] res_q     [STAGES];
   logic [WIDTH-1:0] res_d     [STAGES];
   logic [WIDTH-1:0] a_q       [STAGES];
   logic [WIDTH-1:0] a_d       [STAGES];
   logic [WIDTH-1:0] b_q       [STAGES];
   logic [WIDTH-1:0] b_d       [STAGES];
   logic             msb_cin_w [STAGES];
   logic             msb_cin_q;
   logic             stall;

   // Global enable: only a presented-but-refused result freezes the pipe.
   assign stall    = ctrl_q[STAGES-1].valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] res_src;
      logic             c_src;
      logic             v_src;
      logic [SLICE-1:0] s_w;
      logic             cout_w;

      if (k == 0) begin : g_first
         assign a_src   = a;
         assign b_src   = b;
         assign res_src = '0;
         assign c_src   = carry_in;
         assign v_src   = in_valid;
      end else begin : g_next
         assign a_src   = a_q[k-1];
         assign b_src   = b_q[k-1];
         assign res_src = res_q[k-1];
         assign c_src   = ctrl_q[k-1].carry;
         assign v_src   = ctrl_q[k-1].valid;
      end

      adder_slice #(.SLICE(SLICE)) u_slice (
         .a       (a_src[SLICE-1:0]),
         .b       (b_src[SLICE-1:0]),
         .cin     (c_src),
         .s       (s_w),
         .cout    (cout_w),
         .msb_cin (msb_cin_w[k])
      );

      // Remaining operand slices are shifted down so every stage adds bit 0.
      assign a_d[k]   = a_src >> SLICE;
      assign b_d[k]   = b_src >> SLICE;
      // Bits above the slices already produced are always zero, so OR-in works.
      assign res_d[k] = res_src | (WIDTH'(s_w) << (k * SLICE));
      assign ctrl_d[k] = '{valid: v_src, carry: cout_w};
   end

   // ---- stage registers: control and result slices ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            res_q[k]  <= '0;
         end
         msb_cin_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= ctrl_d[k];
            res_q[k]  <= res_d[k];
         end
         msb_cin_q <= msb_cin_w[STAGES-1];
      end
   end

   // ---- stage registers: skewed operand slices (data only) ----
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
         end
      end
   end

   assign out_valid = ctrl_q[STAGES-1].valid;
   assign sum       = res_q[STAGES-1];
   assign carry_out = ctrl_q[STAGES-1].carry;
   assign overflow  = ctrl_q[STAGES-1].carry ^ msb_cin_q;

endmodule
